// File: rtl/id_serialize_ctrl_pkg.sv
// id_serialize_ctrl_pkg: shared types and sizing for the serializing-instruction issue controller
package id_serialize_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, WAIT_COMMIT} ser_state_t;
  localparam int INFLIGHT_MAX = 16;
  localparam int SER_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/id_serialize_ctrl_inflight_counter.sv
// inflight_counter: saturating up/down counter with clear, full/empty flags and sticky error
module inflight_counter #(
  parameter int MAX = 16,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         error
);
  logic over, under;
  assign full = count == W'(MAX);
  assign empty = count == '0;
  assign over = inc & ~dec & full;
  assign under = dec & ~inc & empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      error <= 1'b0;
    end else if (clr) begin
      count <= '0;
    end else begin
      if (!(over | under)) count <= count + W'(inc) - W'(dec);
      error <= error | over | under;
    end
  end
endmodule

// File: rtl/id_serialize_ctrl.sv
// id_serialize_ctrl: holds serializing instructions in ID until older ones commit, issues them alone
module id_serialize_ctrl #(
  parameter int INFLIGHT_MAX = id_serialize_ctrl_pkg::INFLIGHT_MAX,
  parameter int TIMEOUT_CYCLES = id_serialize_ctrl_pkg::SER_TIMEOUT_CYCLES,
  localparam int CW = $clog2(INFLIGHT_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic          id_serial_i,
  input  logic          id_xcpt_i,
  input  logic          issue_ready_i,
  input  logic          commit_valid_i,
  input  logic          commit_serial_i,
  output logic          issue_valid_o,
  output logic          stall_if_o,
  output logic          stall_id_o,
  output logic          busy_o,
  output logic [CW-1:0] inflight_o,
  output logic          timeout_o,
  output logic          error_o
);
  import id_serialize_ctrl_pkg::*;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  ser_state_t state, state_nx;
  logic [TW-1:0] timer;
  logic ser, fire, full, empty, idle_go, wd_active, wd_expire;
  assign ser = id_valid_i & (id_serial_i | id_xcpt_i);
  assign idle_go = id_valid_i & ~ser & ~full;
  assign fire = issue_valid_o & issue_ready_i;
  assign busy_o = state != IDLE;
  assign wd_active = state == DRAIN || state == WAIT_COMMIT;
  assign wd_expire = wd_active && timer == TW'(TIMEOUT_CYCLES - 1);
  // ISSUE advances on issue_ready_i directly so the next-state logic never depends on issue_valid_o
  always_comb begin
    state_nx = state;
    issue_valid_o = 1'b0;
    stall_if_o = 1'b1;
    stall_id_o = 1'b1;
    unique case (state)
      IDLE: begin
        issue_valid_o = idle_go & ~flush_i;
        stall_id_o = ser | (id_valid_i & full) | (idle_go & ~issue_ready_i);
        stall_if_o = stall_id_o;
        state_nx = ser ? DRAIN : IDLE;
      end
      DRAIN: state_nx = empty ? ISSUE : DRAIN;
      ISSUE: begin
        issue_valid_o = ~flush_i;
        stall_id_o = ~issue_ready_i;
        state_nx = issue_ready_i ? WAIT_COMMIT : ISSUE;
      end
      WAIT_COMMIT: state_nx = (commit_valid_i & commit_serial_i) ? IDLE : WAIT_COMMIT;
      default: state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end
  // DRAIN and WAIT_COMMIT are only entered from states where the timer already sits at zero
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      timer <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (flush_i | ~wd_active | wd_expire) ? '0 : timer + TW'(1);
      timeout_o <= wd_expire & ~flush_i;
    end
  end
  inflight_counter #(.MAX(INFLIGHT_MAX), .W(CW)) u_cnt (
    .clk(clk_i),
    .rst_n(rstn_i),
    .clr(flush_i),
    .inc(fire),
    .dec(commit_valid_i),
    .count(inflight_o),
    .full(full),
    .empty(empty),
    .error(error_o)
  );
endmodule

// File: tb/tb_id_serialize_ctrl.sv
// tb_id_serialize_ctrl: directed self-checking bench for id_serialize_ctrl
module tb_id_serialize_ctrl;
  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0, id_serial = 1'b0, id_xcpt = 1'b0, issue_ready = 1'b1;
  logic commit_valid = 1'b0, commit_serial = 1'b0;
  logic issue_valid, stall_if, stall_id, busy, timeout, error;
  logic [4:0] inflight;
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  id_serialize_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .id_valid_i(id_valid),
    .id_serial_i(id_serial), .id_xcpt_i(id_xcpt), .issue_ready_i(issue_ready),
    .commit_valid_i(commit_valid), .commit_serial_i(commit_serial),
    .issue_valid_o(issue_valid), .stall_if_o(stall_if), .stall_id_o(stall_id),
    .busy_o(busy), .inflight_o(inflight), .timeout_o(timeout), .error_o(error)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL rst_inflight: got %0d want 0", inflight); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else pass_cnt++;
    rstn = 1'b1;
    tick();
    total_cnt++; if (stall_if !== 1'b0) $display("FAIL rst_stall_if: got %b want 0", stall_if); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid: got %b want 0", issue_valid); else pass_cnt++;
  endtask
  task automatic test_plain;
    id_valid = 1'b1;
    #1;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL plain_iv0: got %b want 1", issue_valid); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b0) $display("FAIL plain_stall_if: got %b want 0", stall_if); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL plain_stall_id: got %b want 0", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (inflight !== 5'd1) $display("FAIL plain_cnt1: got %0d want 1", inflight); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL plain_iv1: got %b want 1", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (inflight !== 5'd2) $display("FAIL plain_cnt2: got %0d want 2", inflight); else pass_cnt++;
    id_valid = 1'b0;
  endtask
  task automatic test_drain;
    id_valid = 1'b1;
    tick();
    total_cnt++; if (inflight !== 5'd3) $display("FAIL drain_pre: got %0d want 3", inflight); else pass_cnt++;
    id_serial = 1'b1;
    #1;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL drain_hold_iv: got %b want 0", issue_valid); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b1) $display("FAIL drain_hold_stall: got %b want 1", stall_if); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b1) $display("FAIL drain_stall_if: got %b want 1", stall_if); else pass_cnt++;
    commit_valid = 1'b1;
    repeat (3) tick();
    commit_valid = 1'b0;
    #1;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL drain_cnt0: got %0d want 0", inflight); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL drain_still: got %b want 0", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL drain_issue_iv: got %b want 1", issue_valid); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b1) $display("FAIL drain_issue_sif: got %b want 1", stall_if); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL drain_issue_sid: got %b want 0", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (inflight !== 5'd1) $display("FAIL wait_cnt: got %0d want 1", inflight); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL wait_iv: got %b want 0", issue_valid); else pass_cnt++;
    id_valid = 1'b0; id_serial = 1'b0;
    #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL wait_stall_id: got %b want 1", stall_id); else pass_cnt++;
    commit_valid = 1'b1; commit_serial = 1'b1;
    tick();
    commit_valid = 1'b0; commit_serial = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL commit_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL commit_cnt: got %0d want 0", inflight); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b0) $display("FAIL commit_stall: got %b want 0", stall_if); else pass_cnt++;
  endtask
  task automatic test_min_latency;
    id_valid = 1'b1; id_xcpt = 1'b1;
    #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL lat_stall_id: got %b want 1", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL lat_drain_iv: got %b want 0", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL lat_issue_iv: got %b want 1", issue_valid); else pass_cnt++;
    issue_ready = 1'b0;
    #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL lat_bp_stall: got %b want 1", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL lat_bp_iv: got %b want 1", issue_valid); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL lat_bp_cnt: got %0d want 0", inflight); else pass_cnt++;
    issue_ready = 1'b1;
    tick();
    total_cnt++; if (inflight !== 5'd1) $display("FAIL lat_fire_cnt: got %0d want 1", inflight); else pass_cnt++;
    id_valid = 1'b0; id_xcpt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL lat_flush_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL lat_flush_cnt: got %0d want 0", inflight); else pass_cnt++;
  endtask
  task automatic test_full;
    id_valid = 1'b1;
    repeat (15) tick();
    total_cnt++; if (inflight !== 5'd15) $display("FAIL full_cnt15: got %0d want 15", inflight); else pass_cnt++;
    commit_valid = 1'b1;
    #1;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL full_both_iv: got %b want 1", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (inflight !== 5'd15) $display("FAIL full_both_cnt: got %0d want 15", inflight); else pass_cnt++;
    commit_valid = 1'b0;
    tick();
    total_cnt++; if (inflight !== 5'd16) $display("FAIL full_cnt16: got %0d want 16", inflight); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL full_iv: got %b want 0", issue_valid); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL full_stall_id: got %b want 1", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (inflight !== 5'd16) $display("FAIL full_hold: got %0d want 16", inflight); else pass_cnt++;
    commit_valid = 1'b1;
    tick();
    total_cnt++; if (inflight !== 5'd15) $display("FAIL full_commit: got %0d want 15", inflight); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL full_no_err: got %b want 0", error); else pass_cnt++;
    commit_valid = 1'b0; id_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL full_flush: got %0d want 0", inflight); else pass_cnt++;
  endtask
  task automatic test_flush;
    id_valid = 1'b1;
    repeat (5) tick();
    id_serial = 1'b1;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL fl_drain_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd5) $display("FAIL fl_drain_cnt: got %0d want 5", inflight); else pass_cnt++;
    flush = 1'b1; id_valid = 1'b0; id_serial = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL fl_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL fl_cnt: got %0d want 0", inflight); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b0) $display("FAIL fl_stall: got %b want 0", stall_if); else pass_cnt++;
    id_valid = 1'b1; id_serial = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    #1;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL fl_issue_iv: got %b want 0", issue_valid); else pass_cnt++;
    tick();
    flush = 1'b0; id_valid = 1'b0; id_serial = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL fl_issue_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL fl_issue_cnt: got %0d want 0", inflight); else pass_cnt++;
  endtask
  task automatic test_timeout;
    int early = 0;
    id_valid = 1'b1;
    repeat (2) tick();
    id_serial = 1'b1;
    tick();
    if (timeout !== 1'b0) early++;
    repeat (1023) begin
      tick();
      if (timeout !== 1'b0) early++;
    end
    total_cnt++; if (early != 0) $display("FAIL to_early: got %0d early pulses want 0", early); else pass_cnt++;
    tick();
    total_cnt++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL to_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL to_still_drain: got %b want 0", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (timeout !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", timeout); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd2) $display("FAIL to_cnt: got %0d want 2", inflight); else pass_cnt++;
    flush = 1'b1; id_valid = 1'b0; id_serial = 1'b0;
    tick();
    flush = 1'b0;
  endtask
  task automatic test_error_reset;
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    total_cnt++; if (error !== 1'b1) $display("FAIL err_set: got %b want 1", error); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL err_cnt: got %0d want 0", inflight); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (error !== 1'b1) $display("FAIL err_sticky: got %b want 1", error); else pass_cnt++;
    id_valid = 1'b1; id_serial = 1'b1;
    repeat (3) tick();
    id_valid = 1'b0; id_serial = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL rr_wait_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd1) $display("FAIL rr_wait_cnt: got %0d want 1", inflight); else pass_cnt++;
    #2 rstn = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rr_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (inflight !== 5'd0) $display("FAIL rr_cnt: got %0d want 0", inflight); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL rr_error: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (stall_if !== 1'b0) $display("FAIL rr_stall: got %b want 0", stall_if); else pass_cnt++;
    tick();
    rstn = 1'b1;
    tick();
  endtask
  initial begin
    test_reset();
    test_plain();
    test_drain();
    test_min_latency();
    test_full();
    test_flush();
    test_timeout();
    test_error_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
